// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer_pkg
// Purpose  : Shared types for the accumulator CPU sequencer: opcode and
//            phase encodings plus a decode helper.
// Revision : 1.0  initial release
// ============================================================================
package cpu_sequencer_pkg;

  localparam int c_opcode_w = 3;

  // Instruction opcodes, shared with the alu.
  typedef enum logic [c_opcode_w-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Sequencer phases, one per clock, eight per instruction.
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  // Opcodes that read an operand from memory and write the alu result to ACC.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter with synchronous load and increment; a load
//            takes priority over an increment. Wraps modulo 2**AWIDTH.
// Revision : 1.0  initial release
// ============================================================================
module pc_counter
  import cpu_sequencer_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              load,
  input  logic [AWIDTH-1:0] load_val,
  input  logic              inc,
  output logic [AWIDTH-1:0] pc
);

  logic [AWIDTH-1:0] r_pc;

  // PC register: reset to 0, jump target beats sequential increment.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Eight-phase instruction sequencer for the 8-bit accumulator CPU.
//            Holds PC, IR and ACC, drives the alu and memory strobes.
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic [DWIDTH-1:0] alu_out,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [DWIDTH-1:0] accum,
  output logic [DWIDTH-1:0] data,
  output opcode_t           opcode,
  output state_t            phase,
  output logic              halt
);

  // The instruction word is exactly opcode followed by address.
  if (AWIDTH != DWIDTH - c_opcode_w) begin : g_width_check
    $error("cpu_sequencer: AWIDTH must equal DWIDTH-3");
  end

  state_t            r_phase;
  state_t            w_phase_nxt;
  logic [DWIDTH-1:0] r_ir;
  logic [DWIDTH-1:0] r_acc;
  logic [DWIDTH-1:0] r_data;
  logic              r_halt;

  opcode_t           w_opcode;
  logic [AWIDTH-1:0] w_ir_addr;
  logic [AWIDTH-1:0] w_pc;
  logic              w_aluop;
  logic              w_zero;
  logic              w_ir_load;
  logic              w_data_load;
  logic              w_acc_load;
  logic              w_halt_set;
  logic              w_pc_inc;
  logic              w_pc_load;
  logic              w_rd;
  logic              w_wr;

  assign w_opcode  = opcode_t'(r_ir[DWIDTH-1 -: c_opcode_w]);
  assign w_ir_addr = r_ir[AWIDTH-1:0];
  assign w_aluop   = is_aluop(w_opcode);
  assign w_zero    = (r_acc == '0);

  pc_counter #(
    .AWIDTH   (AWIDTH)
  ) u_pc (
    .clk      (clk),
    .rst_     (rst_),
    .load     (w_pc_load),
    .load_val (w_ir_addr),
    .inc      (w_pc_inc),
    .pc       (w_pc)
  );

  // Next-phase and per-phase decode; a halted sequencer does nothing.
  always_comb begin
    w_phase_nxt = r_phase;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_ir_load   = 1'b0;
    w_data_load = 1'b0;
    w_acc_load  = 1'b0;
    w_halt_set  = 1'b0;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    if (!r_halt) begin
      case (r_phase)
        INST_ADDR: begin
          w_phase_nxt = INST_FETCH;
        end
        INST_FETCH: begin
          w_rd        = 1'b1;
          w_phase_nxt = INST_LOAD;
        end
        INST_LOAD: begin
          w_rd        = 1'b1;
          w_ir_load   = 1'b1;
          w_phase_nxt = IDLE;
        end
        IDLE: begin
          w_rd        = 1'b1;
          w_phase_nxt = OP_ADDR;
        end
        OP_ADDR: begin
          // HLT freezes here with PC still pointing at the HLT itself.
          if (w_opcode == HLT) begin
            w_halt_set = 1'b1;
          end else begin
            w_pc_inc    = 1'b1;
            w_phase_nxt = OP_FETCH;
          end
        end
        OP_FETCH: begin
          w_rd        = w_aluop;
          w_data_load = w_aluop;
          w_phase_nxt = ALU_OP;
        end
        ALU_OP: begin
          w_rd        = w_aluop;
          w_pc_inc    = (w_opcode == SKZ) && w_zero;
          w_phase_nxt = STORE;
        end
        STORE: begin
          w_rd        = w_aluop;
          w_wr        = (w_opcode == STO);
          w_acc_load  = w_aluop;
          w_pc_load   = (w_opcode == JMP);
          w_phase_nxt = INST_ADDR;
        end
        default: begin
          w_phase_nxt = INST_ADDR;
        end
      endcase
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_phase <= INST_ADDR;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // IR, operand, ACC and sticky halt registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_ir   <= '0;
      r_data <= '0;
      r_acc  <= '0;
      r_halt <= 1'b0;
    end else begin
      if (w_ir_load) begin
        r_ir <= mem_rdata;
      end
      if (w_data_load) begin
        r_data <= mem_rdata;
      end
      if (w_acc_load) begin
        r_acc <= alu_out;
      end
      if (w_halt_set) begin
        r_halt <= 1'b1;
      end
    end
  end

  // Instruction fetch uses PC; operand access uses the IR address field.
  assign mem_addr  = (r_phase == INST_ADDR || r_phase == INST_FETCH ||
                      r_phase == INST_LOAD || r_phase == IDLE) ? w_pc : w_ir_addr;
  assign mem_rd    = w_rd;
  assign mem_wr    = w_wr;
  assign mem_wdata = r_acc;
  assign accum     = r_acc;
  assign data      = r_data;
  assign opcode    = w_opcode;
  assign phase     = r_phase;
  assign halt      = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer with a memory, an alu and
//            an instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] mem_rdata;
  logic [7:0] alu_out;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] accum;
  logic [7:0] data;
  opcode_t    opcode;
  state_t     phase;
  logic       halt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [32];

  cpu_sequencer #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .mem_rdata (mem_rdata),
    .alu_out   (alu_out),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .accum     (accum),
    .data      (data),
    .opcode    (opcode),
    .phase     (phase),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, write at the edge ending STORE.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    case (op)
      3'd2: return a + d;
      3'd3: return a & d;
      3'd4: return a ^ d;
      3'd5: return d;
      default: return a;
    endcase
  endfunction

  // alu registers on the falling edge.
  always @(negedge clk) alu_out <= alu_f(opcode, accum, data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural state + step in instr) ----
  logic [7:0] m_mem [32];
  logic [4:0] m_pc;
  logic [7:0] m_ir, m_acc, m_data;
  logic       m_halt;
  int         m_k;
  logic       m_valid = 1'b0;
  state_t     ph_tab [8] = '{INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
                             OP_ADDR, OP_FETCH, ALU_OP, STORE};

  always @(posedge clk) begin : model
    logic [2:0] op;
    logic [4:0] a;
    if (!rst_) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_data = 0; m_halt = 0; m_k = 0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halt) begin
      op = m_ir[7:5];
      a  = m_ir[4:0];
      if (m_k == 2) m_ir = m_mem[m_pc];
      if (m_k == 4) begin
        if (op == 3'd0) m_halt = 1'b1;
        else m_pc = m_pc + 5'd1;
      end
      if (m_k == 5 && op inside {3'd2, 3'd3, 3'd4, 3'd5}) m_data = m_mem[a];
      if (m_k == 6 && op == 3'd1 && m_acc == 8'd0) m_pc = m_pc + 5'd1;
      if (m_k == 7) begin
        if (op == 3'd6) m_mem[a] = m_acc;
        if (op == 3'd7) m_pc = a;
        m_acc = alu_f(op, m_acc, m_data);
      end
      if (!m_halt) m_k = (m_k + 1) % 8;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    logic [2:0] op;
    logic       aluop;
    state_t     e_ph;
    logic [4:0] e_addr;
    logic       e_rd, e_wr;
    if (m_valid) begin
      op     = m_ir[7:5];
      aluop  = op inside {3'd2, 3'd3, 3'd4, 3'd5};
      e_ph   = m_halt ? OP_ADDR : ph_tab[m_k];
      e_addr = (!m_halt && m_k < 4) ? m_pc : m_ir[4:0];
      e_rd   = !m_halt && ((m_k >= 1 && m_k <= 3) || (m_k >= 5 && aluop));
      e_wr   = !m_halt && m_k == 7 && op == 3'd6;
      chk("phase",     32'(phase),     32'(e_ph));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_rd",    32'(mem_rd),    32'(e_rd));
      chk("mem_wr",    32'(mem_wr),    32'(e_wr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_acc));
      chk("accum",     32'(accum),     32'(m_acc));
      chk("data",      32'(data),      32'(m_data));
      chk("opcode",    32'(opcode),    32'(op));
      chk("halt",      32'(halt),      32'(m_halt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 32; i++) begin
      mem[i] = fill;
      m_mem[i] = fill;
    end
  endtask

  task automatic put(input int a, input logic [7:0] v);
    mem[a] = v;
    m_mem[a] = v;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_ = 1'b0;
    run(n);
    chk("rst_phase", 32'(phase), 32'(INST_ADDR));
    chk("rst_pc", 32'(mem_addr), 32'd0);
    chk("rst_acc", 32'(accum), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    rst_ = 1'b1;
  endtask

  initial begin
    // LDA 30 / ADD 31 / STO 29 / HLT
    clear_mem(8'h00);
    put(0, 8'hBE); put(1, 8'h5F); put(2, 8'hDD); put(3, 8'h00);
    put(30, 8'h05); put(31, 8'h03);
    do_reset(3);
    run(8);  chk("t1_acc8", 32'(accum), 32'h05);
    run(8);  chk("t1_acc16", 32'(accum), 32'h08);
             chk("t1_data16", 32'(data), 32'h03);
    run(8);  chk("t1_mem29", 32'(mem[29]), 32'h08);
    run(5);  chk("t1_halt", 32'(halt), 32'd1);
             chk("t1_phase", 32'(phase), 32'(OP_ADDR));
             chk("t1_pc", 32'(dut.w_pc), 32'd3);
    run(10); chk("t1_hold_acc", 32'(accum), 32'h08);
             chk("t1_hold_halt", 32'(halt), 32'd1);

    // SKZ with ACC=0 skips the HLT; reset while halted
    clear_mem(8'h00);
    put(0, 8'h20); put(1, 8'h00); put(2, 8'hBE); put(3, 8'h00); put(30, 8'h07);
    do_reset(3);
    run(8);  chk("skz0_pc", 32'(mem_addr), 32'd2);
    run(8);  chk("skz0_acc", 32'(accum), 32'h07);
             chk("skz0_nohalt", 32'(halt), 32'd0);
    run(5);  chk("skz0_halt", 32'(halt), 32'd1);
             chk("skz0_hpc", 32'(dut.w_pc), 32'd3);

    // SKZ with ACC=1 executes the HLT
    clear_mem(8'h00);
    put(0, 8'hBE); put(1, 8'h20); put(2, 8'h00); put(3, 8'hBF);
    put(30, 8'h01); put(31, 8'h09);
    do_reset(3);
    run(8);  chk("skz1_acc", 32'(accum), 32'h01);
    run(8);  chk("skz1_pc", 32'(mem_addr), 32'd2);
    run(5);  chk("skz1_halt", 32'(halt), 32'd1);
             chk("skz1_hpc", 32'(dut.w_pc), 32'd2);
             chk("skz1_acc_hold", 32'(accum), 32'h01);

    // JMP 7 at 0, JMP 31 at 7, JMP 5 at 31, HLT at 5
    clear_mem(8'h00);
    put(0, 8'hE7); put(7, 8'hFF); put(31, 8'hE5);
    do_reset(3);
    run(8);  chk("jmp_7", 32'(mem_addr), 32'd7);
    run(8);  chk("jmp_31", 32'(mem_addr), 32'd31);
    run(8);  chk("jmp_from31", 32'(mem_addr), 32'd5);
    run(5);  chk("jmp_halt", 32'(halt), 32'd1);
             chk("jmp_hpc", 32'(dut.w_pc), 32'd5);

    // PC wrap with XOR 0 everywhere (ACC toggles by 0x80 each instruction)
    clear_mem(8'h80);
    do_reset(3);
    run(31 * 8); chk("wrap_pc31", 32'(mem_addr), 32'd31);
                 chk("wrap_acc31", 32'(accum), 32'h80);
    run(8);      chk("wrap_pc0", 32'(mem_addr), 32'd0);
                 chk("wrap_acc", 32'(accum), 32'h00);
                 chk("wrap_halt", 32'(halt), 32'd0);

    // Reset during ALU_OP of an ADD
    clear_mem(8'h00);
    put(0, 8'hBE); put(1, 8'h5F); put(30, 8'h05); put(31, 8'h03);
    do_reset(3);
    run(8);  chk("mid_acc", 32'(accum), 32'h05);
    run(6);  chk("mid_phase", 32'(phase), 32'(ALU_OP));
    rst_ = 1'b0;
    run(1);  chk("mid_rst_phase", 32'(phase), 32'(INST_ADDR));
             chk("mid_rst_acc", 32'(accum), 32'h00);
             chk("mid_rst_data", 32'(data), 32'h00);
             chk("mid_rst_ir", 32'(opcode), 32'(HLT));
             chk("mid_rst_rd", 32'(mem_rd), 32'd0);
    rst_ = 1'b1;
    run(8);  chk("mid_after_acc", 32'(accum), 32'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
